// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory
// for the load/store unit.
module dmem_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT =
    33'(DEPTH) * 33'd4;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic          f3_ok;
  logic          mis;
  logic          oor;
  logic          acc_err;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   wd_rep;
  logic [31:0]   st_word;
  logic          access;
  logic          do_write;

  assign widx = addr_q[AW+1:2];
  assign lane = addr_q[1:0];
  assign word = mem[widx];

  always_comb begin
    bsel  = word[{lane, 3'b000} +: 8];
    hsel  = addr_q[1] ? word[31:16]
                      : word[15:0];
    f3_ok = wr_q
      ? (f3_q inside {3'b000, 3'b001, 3'b010})
      : !(f3_q inside {3'b011, 3'b110, 3'b111});
    mis = ((f3_q[1:0] == 2'b01) && addr_q[0])
       || ((f3_q[1:0] == 2'b10)
           && (lane != 2'b00));
    oor = {1'b0, addr_q} >= LIMIT;
    acc_err = !f3_ok || mis || oor;

    ld_data = 32'h0;
    case (f3_q)
      3'b000:  ld_data = {{24{bsel[7]}}, bsel};
      3'b100:  ld_data = {24'h0, bsel};
      3'b001:  ld_data = {{16{hsel[15]}}, hsel};
      3'b101:  ld_data = {16'h0, hsel};
      3'b010:  ld_data = word;
      default: ld_data = 32'h0;
    endcase

    be     = 4'b1111;
    wd_rep = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100
                           : 4'b0011;
        wd_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = wdata_q;
      end
    endcase

    st_word = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i])
        st_word[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

  assign access =
    (state_q == WAIT) && (cnt_q == 4'd0);
  assign do_write =
    access && wr_q && !acc_err;

  always_ff @(posedge clk) begin
    if (do_write) mem[widx] <= st_word;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = LAT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (acc_err || wr_q)
                  ? 32'h0 : ld_data;
          err_d   = acc_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == IDLE && req_valid) begin
        wr_q    <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, corner sequences and random traffic
// against a byte-addressed reference model; LATENCY 2 and 0 instances.
module tb_dmem_responder;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;

   logic        a_req_ready, a_rsp_valid, a_rsp_err;
   logic [31:0] a_rsp_rdata;
   logic        b_req_ready, b_rsp_valid, b_rsp_err;
   logic [31:0] b_rsp_rdata;

   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   assign req_ready = sel ? b_req_ready : a_req_ready;
   assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
   assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
      .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & sel), .req_ready(b_req_ready),
      .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference: memory as individual bytes, rules from the ISA description.
   logic [7:0] mb [int unsigned];

   function automatic void model(input bit w, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] rd, output bit err);
      int size;
      bit legal;
      logic [31:0] v;
      legal = w ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      size  = 1 << f3[1:0];
      err   = !legal || ((a % 32'(size)) != 0) || (a >= 32'(DEPTH * 4));
      rd    = 32'h0;
      if (err) return;
      if (w) begin
         for (int i = 0; i < size; i++) mb[a + 32'(i)] = wd[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < size; i++)
            v = v | (32'(mb[a + 32'(i)]) << (8 * i));
         if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
         if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         rd = v;
      end
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_req(input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int hold, output logic [31:0] rd,
                         output logic err, output int lat);
      int n;
      rd  = 32'h0;
      err = 1'b0;
      lat = 0;
      wait_ready();
      if (req_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL req_ready timeout: got %b required 1", req_ready);
         return;
      end
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (rsp_valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL rsp_valid timeout: got %b required 1", rsp_valid);
         return;
      end
      lat = n;
      rd  = rsp_rdata;
      err = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk1("hold_valid", rsp_valid, 1'b1);
         chk("hold_rdata", rsp_rdata, rd);
         chk1("hold_req_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk1("rsp_valid_clear", rsp_valid, 1'b0);
      chk("rsp_rdata_clear", rsp_rdata, 32'h0);
   endtask

   typedef struct {
      bit          w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          err;
   } vec_t;

   function automatic vec_t v(input bit w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input bit err);
      vec_t r;
      r.w = w; r.f3 = f3; r.a = a; r.wd = wd; r.rd = rd; r.err = err;
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[$];
      logic [31:0] rd, mrd, snap;
      logic        err;
      bit          merr, w;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      int          lat, r, n;

      tbl.push_back(v(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0));
      tbl.push_back(v(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0));
      tbl.push_back(v(1, 3'b000, 32'h11,  32'h000000AA, 32'h0,        0));
      tbl.push_back(v(0, 3'b010, 32'h10,  32'h0,        32'hDEADAAEF, 0));
      tbl.push_back(v(1, 3'b001, 32'h12,  32'h00001234, 32'h0,        0));
      tbl.push_back(v(0, 3'b010, 32'h10,  32'h0,        32'h1234AAEF, 0));
      tbl.push_back(v(1, 3'b010, 32'h10,  32'h80F07F81, 32'h0,        0));
      tbl.push_back(v(0, 3'b000, 32'h10,  32'h0,        32'hFFFFFF81, 0));
      tbl.push_back(v(0, 3'b100, 32'h13,  32'h0,        32'h00000080, 0));
      tbl.push_back(v(0, 3'b001, 32'h12,  32'h0,        32'hFFFF80F0, 0));
      tbl.push_back(v(0, 3'b101, 32'h12,  32'h0,        32'h000080F0, 0));
      tbl.push_back(v(0, 3'b010, 32'h12,  32'h0,        32'h0,        1));
      tbl.push_back(v(1, 3'b001, 32'h13,  32'h0000FFFF, 32'h0,        1));
      tbl.push_back(v(0, 3'b010, 32'h1000, 32'h0,       32'h0,        1));
      tbl.push_back(v(0, 3'b011, 32'h10,  32'h0,        32'h0,        1));
      tbl.push_back(v(1, 3'b100, 32'h10,  32'h000000FF, 32'h0,        1));
      tbl.push_back(v(0, 3'b010, 32'h10,  32'h0,        32'h80F07F81, 0));
      tbl.push_back(v(1, 3'b010, 32'hFFC, 32'h0BADF00D, 32'h0,        0));
      tbl.push_back(v(0, 3'b010, 32'hFFC, 32'h0,        32'h0BADF00D, 0));
      tbl.push_back(v(0, 3'b001, 32'hFFD, 32'h0,        32'h0,        1));
      tbl.push_back(v(0, 3'b000, 32'hFFF, 32'h0,        32'h0000000B, 0));

      reset      = 1'b0;
      sel        = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;

      #12;
      chk1("reset_req_ready", req_ready, 1'b1);
      chk1("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk1("reset_rsp_err", rsp_err, 1'b0);
      sel = 1'b1;
      #1;
      chk1("reset0_req_ready", req_ready, 1'b1);
      chk1("reset0_rsp_valid", rsp_valid, 1'b0);
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         do_req(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, 0, rd, err, lat);
         model(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, mrd, merr);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
         chk1($sformatf("tbl%0d_err", i), err, tbl[i].err);
         chk($sformatf("tbl%0d_latency", i), lat, 3);
      end

      // Backpressure with store traffic on the request pins while held.
      wait_ready();
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      @(posedge clk); #1;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         req_write = 1'b1;
         req_wdata = $urandom;
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk1("bp_valid", rsp_valid, 1'b1);
         chk("bp_rdata", rsp_rdata, 32'h80F07F81);
         chk1("bp_err", rsp_err, 1'b0);
         chk1("bp_req_ready", req_ready, 1'b0);
         req_write  = 1'b1;
         req_funct3 = 3'b010;
         req_addr   = 32'h10;
         req_wdata  = $urandom;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk1("bp_release", rsp_valid, 1'b0);
      do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, err, lat);
      chk("bp_after_lw", rd, 32'h80F07F81);

      // Reset during WAIT aborts a store (LATENCY 2).
      do_req(1, 3'b010, 32'h20, 32'h11111111, 0, rd, err, lat);
      model(1, 3'b010, 32'h20, 32'h11111111, mrd, merr);
      wait_ready();
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      req_wdata  = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk1("abort_req_ready", req_ready, 1'b1);
      chk1("abort_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      do_req(0, 3'b010, 32'h20, 32'h0, 0, rd, err, lat);
      chk("abort_lw", rd, 32'h11111111);

      // Reset while an error response is held clears it at once.
      wait_ready();
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h22;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk1("resp_err_set", rsp_err, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk1("resp_reset_valid", rsp_valid, 1'b0);
      chk1("resp_reset_err", rsp_err, 1'b0);
      chk1("resp_reset_ready", req_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // LATENCY 0 instance.
      sel = 1'b1;
      #1;
      do_req(1, 3'b010, 32'h20, 32'h22222222, 0, rd, err, lat);
      chk("l0_sw_latency", lat, 1);
      do_req(0, 3'b010, 32'h20, 32'h0, 0, rd, err, lat);
      chk("l0_lw_rdata", rd, 32'h22222222);
      chk("l0_lw_latency", lat, 1);
      wait_ready();
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      req_wdata  = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      do_req(0, 3'b010, 32'h20, 32'h0, 0, rd, err, lat);
      chk("l0_abort_lw", rd, 32'h22222222);
      do_req(1, 3'b000, 32'h21, 32'h00000055, 0, rd, err, lat);
      do_req(0, 3'b010, 32'h20, 32'h0, 0, rd, err, lat);
      chk("l0_sb_lw", rd, 32'h22225522);
      chk("l0_sb_lw_latency", lat, 1);
      sel = 1'b0;
      #1;

      // Random traffic on the LATENCY 2 instance against the model.
      for (int i = 0; i < 16; i++) begin
         a  = 32'(i * 4);
         wd = $urandom;
         do_req(1, 3'b010, a, wd, 0, rd, err, lat);
         model(1, 3'b010, a, wd, mrd, merr);
      end
      for (int i = 0; i < 300; i++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         r  = int'($urandom_range(0, 9));
         if (r == 0)      a = 32'hFFC + 32'($urandom_range(0, 7));
         else if (r == 1) a = 32'h8000_0000 | $urandom;
         else             a = 32'($urandom_range(0, 63));
         wd = $urandom;
         do_req(w, f3, a, wd, int'($urandom_range(0, 2)), rd, err, lat);
         model(w, f3, a, wd, mrd, merr);
         snap = {w, f3, a[27:0]};
         chk($sformatf("rnd%0d_rdata[%h]", i, snap), rd, mrd);
         chk1($sformatf("rnd%0d_err", i), err, merr);
         chk($sformatf("rnd%0d_latency", i), lat, 3);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
